uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Each frame is 1 start bit (low),
// DATA_WIDTH data bits LSB first, then 1 stop bit (high). Data bits and the
// stop bit are sampled at mid-bit. A good word is delivered with a one-cycle
// o_Rx_DV pulse. A low stop bit gives a one-cycle o_Rx_Framing_Err pulse.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, an even
// parity bit follows the data bits, and a mismatch pulses o_Rx_Parity_Err
// at the stop sample.
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_DV,
    output logic [DATA_WIDTH-1:0] o_Rx_Byte,
    output logic                  o_Rx_Active,
    output logic                  o_Rx_Framing_Err,
    output logic                  o_Rx_Parity_Err
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_State;
    logic                  r_Sync1;
    logic                  r_Sync2;
    logic                  w_Rx_S;
    logic [CNT_W-1:0]      r_Clk_Cnt;
    logic [IDX_W-1:0]      r_Bit_Idx;
    logic [DATA_WIDTH-1:0] r_Shift;
    logic [DATA_WIDTH-1:0] r_Rx_Byte;
    logic                  r_Rx_DV;
    logic                  r_Active;
    logic                  r_Framing_Err;
`ifdef UART_RX_PARITY_EN
    logic                  r_Parity_Bit;
    logic                  r_Parity_Err;
    logic                  w_Parity_Bad;

    // Even parity: data XOR parity must reduce to 0.
    assign w_Parity_Bad    = ^{r_Shift, r_Parity_Bit};
    assign o_Rx_Parity_Err = r_Parity_Err;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

    assign w_Rx_S           = r_Sync2;
    assign o_Rx_DV          = r_Rx_DV;
    assign o_Rx_Byte        = r_Rx_Byte;
    assign o_Rx_Active      = r_Active;
    assign o_Rx_Framing_Err = r_Framing_Err;

    // Two-flop synchronizer for the asynchronous pin; it resets to the idle level.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
        end else begin
            r_Sync1 <= i_Rx_Serial;
            r_Sync2 <= r_Sync1;
        end
    end

    // Frame FSM: check the start bit at mid-bit, then sample each later bit
    // one full period on. All outputs are registered here.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State       <= S_IDLE;
            r_Clk_Cnt     <= '0;
            r_Bit_Idx     <= '0;
            r_Shift       <= '0;
            r_Rx_Byte     <= '0;
            r_Rx_DV       <= 1'b0;
            r_Active      <= 1'b0;
            r_Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Parity_Bit  <= 1'b0;
            r_Parity_Err  <= 1'b0;
`endif
        end else begin
            r_Rx_DV       <= 1'b0;
            r_Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Parity_Err  <= 1'b0;
`endif
            case (r_State)
                S_IDLE: begin
                    r_Clk_Cnt <= '0;
                    if (!w_Rx_S) begin
                        r_State  <= S_START;
                        r_Active <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_Clk_Cnt == HALF_CNT) begin
                        r_Clk_Cnt <= '0;
                        r_Bit_Idx <= '0;
                        if (!w_Rx_S) begin
                            r_State <= S_DATA;
                        end else begin
                            // The line went high before mid-bit, so treat it as a glitch.
                            r_State  <= S_IDLE;
                            r_Active <= 1'b0;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_Clk_Cnt == FULL_CNT) begin
                        r_Clk_Cnt          <= '0;
                        r_Shift[r_Bit_Idx] <= w_Rx_S;
                        if (r_Bit_Idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            r_State <= S_PARITY;
`else
                            r_State <= S_STOP;
`endif
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + IDX_W'(1);
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_Clk_Cnt == FULL_CNT) begin
                        r_Clk_Cnt    <= '0;
                        r_Parity_Bit <= w_Rx_S;
                        r_State      <= S_STOP;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_Clk_Cnt == FULL_CNT) begin
                        r_Clk_Cnt <= '0;
                        r_State   <= S_IDLE;
                        r_Active  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (w_Rx_S && !w_Parity_Bad) begin
                            r_Rx_Byte <= r_Shift;
                            r_Rx_DV   <= 1'b1;
                        end
                        r_Framing_Err <= ~w_Rx_S;
                        r_Parity_Err  <= w_Parity_Bad;
`else
                        if (w_Rx_S) begin
                            r_Rx_Byte <= r_Shift;
                            r_Rx_DV   <= 1'b1;
                        end else begin
                            r_Framing_Err <= 1'b1;
                        end
`endif
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_State  <= S_IDLE;
                    r_Active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Stimulus is driven on the falling
// clock edge, and DUT pulses are logged on the falling edge.
module tb_uart_rx;
    localparam int DW  = 8;
    localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FRAME = NB * CPB;
    localparam int LAT   = 3 + (CPB - 1) / 2 + (NB - 1) * CPB;
    localparam int BRK_P = LAT - 2;
    localparam int HOLD  = LAT + BRK_P + 24;

    logic          i_Clock = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Rx_Serial = 1'b1;
    logic          o_Rx_DV;
    logic [DW-1:0] o_Rx_Byte;
    logic          o_Rx_Active;
    logic          o_Rx_Framing_Err;
    logic          o_Rx_Parity_Err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dv_cnt  = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int act_cnt = 0;
    bit both_hi = 1'b0;
    logic [DW-1:0] dv_byte[$];
    int            dv_cyc[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .i_Clock          (i_Clock),
        .i_Rst_n          (i_Rst_n),
        .i_Rx_Serial      (i_Rx_Serial),
        .o_Rx_DV          (o_Rx_DV),
        .o_Rx_Byte        (o_Rx_Byte),
        .o_Rx_Active      (o_Rx_Active),
        .o_Rx_Framing_Err (o_Rx_Framing_Err),
        .o_Rx_Parity_Err  (o_Rx_Parity_Err)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc++;

    always @(negedge i_Clock) begin
        if (o_Rx_DV) begin
            dv_cnt++;
            dv_byte.push_back(o_Rx_Byte);
            dv_cyc.push_back(cyc);
        end
        if (o_Rx_Framing_Err) fe_cnt++;
        if (o_Rx_Parity_Err) pe_cnt++;
        if (o_Rx_Active) act_cnt++;
        if (o_Rx_DV && o_Rx_Framing_Err) both_hi = 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold_line(input logic v, input int n);
        i_Rx_Serial = v;
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic stop, output int t0);
        t0 = cyc;
        hold_line(1'b0, CPB);
        for (int i = 0; i < DW; i++) hold_line(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold_line((^d) ^ par_flip, CPB);
`endif
        hold_line(stop, CPB);
    endtask

    initial begin
        int t0, t1, t2, base, fbase, abase, lat;
        logic [DW-1:0] ab;

        // Reset values
        repeat (5) @(negedge i_Clock);
        check("rst_dv", o_Rx_DV, 0);
        check("rst_byte", o_Rx_Byte, 0);
        check("rst_active", o_Rx_Active, 0);
        check("rst_fe", o_Rx_Framing_Err, 0);
        check("rst_pe", o_Rx_Parity_Err, 0);
        i_Rst_n = 1'b1;
        repeat (10) @(negedge i_Clock);

        // Single frame 0xA5
        base = dv_cnt;
        send(8'hA5, 1'b1, t0);
        hold_line(1'b1, 50);
        check("a5_dv_count", dv_cnt - base, 1);
        check("a5_byte", o_Rx_Byte, 8'hA5);
        lat = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] - t0 : -1;
        check("a5_latency_in_range", int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        check("a5_no_fe", fe_cnt, 0);

        // Back-to-back frames 0x00, 0xFF, 0x55
        base = dv_cnt;
        send(8'h00, 1'b1, t0);
        send(8'hFF, 1'b1, t1);
        send(8'h55, 1'b1, t2);
        hold_line(1'b1, 50);
        check("b2b_dv_count", dv_cnt - base, 3);
        if (dv_cnt - base == 3) begin
            check("b2b_byte0", dv_byte[base], 8'h00);
            check("b2b_byte1", dv_byte[base+1], 8'hFF);
            check("b2b_byte2", dv_byte[base+2], 8'h55);
            check("b2b_gap01", dv_cyc[base+1] - dv_cyc[base], FRAME);
            check("b2b_gap12", dv_cyc[base+2] - dv_cyc[base+1], FRAME);
        end

        // 30-clock glitch on an idle line
        base = dv_cnt; fbase = fe_cnt; abase = act_cnt;
        hold_line(1'b0, 30);
        hold_line(1'b1, 200);
        check("glitch_no_dv", dv_cnt - base, 0);
        check("glitch_no_fe", fe_cnt - fbase, 0);
        check("glitch_active_len_ok",
              int'(act_cnt - abase >= 42 && act_cnt - abase <= 46), 1);

        // Frame 0x3C with the stop bit low
        base = dv_cnt; fbase = fe_cnt;
        send(8'h3C, 1'b0, t0);
        hold_line(1'b1, 300);
        check("stoplow_fe", fe_cnt - fbase, 1);
        check("stoplow_no_dv", dv_cnt - base, 0);
        check("stoplow_byte_kept", o_Rx_Byte, 8'h55);

        // Reset during data bit 4 of 0x96, then send 0x69
        base = dv_cnt;
        ab = 8'h96;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold_line(ab[i], CPB);
        hold_line(ab[4], CPB / 2);
        i_Rst_n = 1'b0;
        hold_line(1'b1, 5);
        check("midrst_active", o_Rx_Active, 0);
        check("midrst_byte", o_Rx_Byte, 0);
        i_Rst_n = 1'b1;
        hold_line(1'b1, 100);
        check("midrst_no_dv", dv_cnt - base, 0);
        send(8'h69, 1'b1, t0);
        hold_line(1'b1, 50);
        check("after_rst_dv_count", dv_cnt - base, 1);
        check("after_rst_byte", o_Rx_Byte, 8'h69);

        // Break: line held low for two frame times
        base = dv_cnt; fbase = fe_cnt;
        hold_line(1'b0, HOLD);
        hold_line(1'b1, 300);
        check("break_fe_count", fe_cnt - fbase, 2);
        check("break_no_dv", dv_cnt - base, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: correct, then inverted
        base = dv_cnt; fbase = pe_cnt;
        par_flip = 1'b0;
        send(8'hA5, 1'b1, t0);
        hold_line(1'b1, 50);
        check("par_ok_dv", dv_cnt - base, 1);
        check("par_ok_byte", o_Rx_Byte, 8'hA5);
        check("par_ok_no_pe", pe_cnt - fbase, 0);
        base = dv_cnt;
        par_flip = 1'b1;
        send(8'hA5, 1'b1, t0);
        hold_line(1'b1, 50);
        check("par_bad_pe", pe_cnt - fbase, 1);
        check("par_bad_no_dv", dv_cnt - base, 0);
        par_flip = 1'b0;
`else
        check("no_parity_pe", pe_cnt, 0);
`endif

        check("dv_fe_never_together", int'(both_hi), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
